edge_detect_multi: RTL and testbench
====================================

Name: edge_detect_multi

Overview:
- Parametrised multi-channel edge detector and successor to the single-channel falling-edge detector used on the serial RX line.
- Each channel gets a configurable synchroniser, a glitch filter (minimum stable time), per-channel edge-mode selection, one-cycle rise/fall pulses, and a sticky event flag with a clear handshake.
- Sits between raw pad inputs (RX line, CTS, buttons) and the UART control/interrupt logic.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILTER_CYCLES, 4, consecutive cycles a new level must persist before it is accepted (>=1).
- RESET_LEVEL, 1, level loaded into synchroniser and stable-level registers at reset (UART idle high). Prevents a spurious edge after reset.
- EVT_CNT_W, 8, event-counter width; used only with EDGE_DETECT_COUNT_EN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- signal_in  input  CHANNELS  raw asynchronous inputs; bit i is channel i.
- edge_mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both. Quasi-static; sampled every cycle.
- event_clear  input  CHANNELS  one-cycle clear strobe per channel.
- level_out  output  CHANNELS  filtered stable level.
- rise_pulse  output  CHANNELS  one-cycle pulse on an accepted 0->1 transition (independent of edge_mode).
- fall_pulse  output  CHANNELS  one-cycle pulse on an accepted 1->0 transition (independent of edge_mode).
- event_pending  output  CHANNELS  sticky flag: a mode-selected edge has occurred.
- irq  output  1  OR of all event_pending bits, registered.
- event_count  output  CHANNELS*EVT_CNT_W  only with EDGE_DETECT_COUNT_EN.

Behaviour:
- Reset (async assert, sync release), state loaded:
  - synchroniser flops and level_out = {CHANNELS{RESET_LEVEL}}
  - filter counters = 0
  - rise_pulse = 0, fall_pulse = 0, event_pending = 0, irq = 0, event_count = 0
- A reset asserted mid-filter discards the partial count. No pulse is produced on reset release.
- Synchroniser: s[0] <= signal_in, s[n] <= s[n-1]. Call the last stage sync.
- Filter, per channel, on every clk edge:
  - sync == level_out: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: level_out <= sync, cnt <= 0, and rise_pulse or fall_pulse <= 1 per direction.
  - Else: cnt <= cnt+1.
  - cnt width is clog2(FILTER_CYCLES), minimum 1 bit.
- Latency: input changes and is held from before edge k. s[0] captures at edge k. The pulse is high during the cycle after edge k+SYNC_STAGES+FILTER_CYCLES-1, for exactly 1 cycle. level_out changes at the same edge.
- Glitch rejection: any return to the old level before FILTER_CYCLES consecutive mismatches resets cnt. No level change, no pulse.
- Pulses are registered and cleared the cycle after they assert. Back-to-back accepted edges are at least FILTER_CYCLES cycles apart.
- Event qualify: ev[i] = (rise_pulse[i] & mode[0]) | (fall_pulse[i] & mode[1]), evaluated in the pulse cycle.
- event_pending[i]:
  - set on ev[i]
  - cleared by event_clear[i]
  - simultaneous ev and clear: set wins (no event lost)
  - clear while not pending: no effect
- irq <= |event_pending, i.e. one cycle after the pending update.
- Changing edge_mode does not alter existing pending flags.
- Channels are fully independent; no cross-channel interaction except irq.

Optional Feature:
- Macro EDGE_DETECT_COUNT_EN.
- Defined:
  - Per-channel event_count[i] increments by 1 on each ev[i] and saturates at all ones (no wrap).
  - event_clear[i] zeroes the count in the same edge.
  - Simultaneous ev and clear: count <= 1.
  - event_count port present.
- Undefined: counters and the event_count port are absent; all other behaviour is identical.

Test Plan:
- Reset with signal_in=4'hF, RESET_LEVEL=1, then release -> level_out=4'hF, no pulses, irq=0 for 20 cycles.
- Defaults; ch0 mode=10; ch0 driven 1->0 and held -> fall_pulse[0] high exactly 1 cycle at edge k+5; event_pending[0]=1; irq=1 one cycle later.
- ch1 low glitch of 3 cycles (FILTER_CYCLES=4) -> no pulse, level_out[1] stays 1. Repeat with 4 cycles -> fall_pulse[1] then rise_pulse[1].
- ch2 mode=11; event_clear[2] asserted in the same cycle as the fall pulse -> event_pending[2] remains 1. Clear on the next cycle -> 0, irq drops one cycle later.
- ch3 mode=00 with toggles -> rise_pulse/fall_pulse toggle, event_pending[3]=0. Async reset mid-filter (cnt=2) -> all outputs 0 or RESET_LEVEL immediately, no pulse after release.
- With EDGE_DETECT_COUNT_EN, EVT_CNT_W=2, 5 rises on ch0 mode=01 -> event_count[0]=3 (saturated). event_clear -> 0.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: synchroniser, glitch filter, rise/fall pulses,
// sticky event flags with irq. Define EDGE_DETECT_COUNT_EN for per-channel saturating event counters.
module edge_detect_multi #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int RESET_LEVEL   = 1,
  parameter int EVT_CNT_W     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             signal_in,
  input  logic [2*CHANNELS-1:0]           edge_mode,
  input  logic [CHANNELS-1:0]             event_clear,
  output logic [CHANNELS-1:0]             level_out,
  output logic [CHANNELS-1:0]             rise_pulse,
  output logic [CHANNELS-1:0]             fall_pulse,
  output logic [CHANNELS-1:0]             event_pending,
  output logic                            irq
`ifdef EDGE_DETECT_COUNT_EN
  ,
  output logic [CHANNELS*EVT_CNT_W-1:0]   event_count
`endif
);

  localparam logic [CHANNELS-1:0] RST_VEC = (RESET_LEVEL != 0) ? '1 : '0;
  localparam int                  CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  if (CHANNELS < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 1 || EVT_CNT_W < 1) begin : g_bad_param
    $error("edge_detect_multi: illegal parameter value");
  end

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] ev;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned n = 0; n < SYNC_STAGES; n++) sync_q[n] <= RST_VEC;
    end else begin
      sync_q[0] <= signal_in;
      for (int unsigned n = 1; n < SYNC_STAGES; n++) sync_q[n] <= sync_q[n-1];
    end
  end

  // Counter tracks consecutive cycles the synchronised input disagrees with level_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_out  <= RST_VEC;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        rise_pulse[i] <= 1'b0;
        fall_pulse[i] <= 1'b0;
        if (sync[i] == level_out[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level_out[i]  <= sync[i];
          cnt[i]        <= '0;
          rise_pulse[i] <= sync[i];
          fall_pulse[i] <= ~sync[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ev = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      ev[i] = (rise_pulse[i] & edge_mode[2*i]) | (fall_pulse[i] & edge_mode[2*i+1]);
    end
  end

  // A new event outranks a simultaneous clear so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      event_pending <= '0;
      irq           <= 1'b0;
    end else begin
      event_pending <= ev | (event_pending & ~event_clear);
      irq           <= |event_pending;
    end
  end

`ifdef EDGE_DETECT_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      event_count <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (event_clear[i]) begin
          event_count[i*EVT_CNT_W +: EVT_CNT_W] <= EVT_CNT_W'(ev[i]);
        end else if (ev[i] && (event_count[i*EVT_CNT_W +: EVT_CNT_W] != '1)) begin
          event_count[i*EVT_CNT_W +: EVT_CNT_W] <= event_count[i*EVT_CNT_W +: EVT_CNT_W] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: window-based reference model compared every cycle,
// directed literal checks, then randomized stimulus.
module tb_edge_detect_multi;

  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int FC   = 4;
  localparam int RL   = 1;
  localparam int CW   = 2;
  localparam int HL   = SS + FC - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH-1:0]     signal_in;
  logic [2*CH-1:0]   edge_mode;
  logic [CH-1:0]     event_clear;
  logic [CH-1:0]     level_out, rise_pulse, fall_pulse, event_pending;
  logic              irq;
`ifdef EDGE_DETECT_COUNT_EN
  logic [CH*CW-1:0]  event_count;
`endif

  edge_detect_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .RESET_LEVEL(RL), .EVT_CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .signal_in(signal_in), .edge_mode(edge_mode),
    .event_clear(event_clear), .level_out(level_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .event_pending(event_pending), .irq(irq)
`ifdef EDGE_DETECT_COUNT_EN
    , .event_count(event_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Reference model: a level is accepted when the filter's last FC samples
  // (the input as seen SS edges late) all disagree with the current level.
  logic [HL-1:0] inh [CH];
  logic [CH-1:0] m_level, m_rise, m_fall, m_pend;
  logic          m_irq, m_ev, m_acc;
`ifdef EDGE_DETECT_COUNT_EN
  int            m_cnt [CH];
`endif

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        inh[c] = (RL != 0) ? '1 : '0;
`ifdef EDGE_DETECT_COUNT_EN
        m_cnt[c] = 0;
`endif
      end
      m_level = (RL != 0) ? '1 : '0;
      m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
    end else begin
      m_irq = |m_pend;
      for (int c = 0; c < CH; c++) begin
        m_ev = (m_rise[c] && edge_mode[2*c]) || (m_fall[c] && edge_mode[2*c+1]);
`ifdef EDGE_DETECT_COUNT_EN
        if (event_clear[c]) m_cnt[c] = m_ev ? 1 : 0;
        else if (m_ev && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
`endif
        m_pend[c] = m_ev || (m_pend[c] && !event_clear[c]);
        m_acc = 1'b1;
        for (int j = SS - 1; j < HL; j++) if (inh[c][j] == m_level[c]) m_acc = 1'b0;
        m_rise[c] = m_acc && !m_level[c];
        m_fall[c] = m_acc && m_level[c];
        if (m_acc) m_level[c] = !m_level[c];
        inh[c] = {inh[c][HL-2:0], signal_in[c]};
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("level_out", level_out, m_level);
      chk("rise_pulse", rise_pulse, m_rise);
      chk("fall_pulse", fall_pulse, m_fall);
      chk("event_pending", event_pending, m_pend);
      chk("irq", irq, m_irq);
`ifdef EDGE_DETECT_COUNT_EN
      for (int c = 0; c < CH; c++) chk("event_count", event_count[c*CW +: CW], m_cnt[c]);
`endif
    end
  end

  int n_rise, n_fall;
  int hold [CH];

  initial begin
    reset = 1'b0; signal_in = '1; edge_mode = '0; event_clear = '0;
    repeat (3) tick;
    reset = 1'b1;
    run_cmp = 1'b1;

    // Quiet after reset: no spurious edges.
    repeat (20) begin
      tick;
      chk("rst_level", level_out, 4'hF);
      chk("rst_pulses", rise_pulse | fall_pulse, 4'h0);
      chk("rst_irq", irq, 1'b0);
    end

    // ch0 fall, mode 10: pulse visible after edge k+5.
    edge_mode = 8'b00_00_00_10;
    signal_in[0] = 1'b0;
    repeat (5) tick;
    chk("fall0_early", fall_pulse[0], 1'b0);
    tick;
    chk("fall0_pulse", fall_pulse[0], 1'b1);
    chk("fall0_level", level_out[0], 1'b0);
    tick;
    chk("fall0_once", fall_pulse[0], 1'b0);
    chk("pend0_set", event_pending[0], 1'b1);
    chk("irq_lag", irq, 1'b0);
    tick;
    chk("irq_set", irq, 1'b1);

    // Glitch rejection on ch1, then a 4-cycle low that is accepted.
    event_clear = '1; tick; event_clear = '0; tick;
    signal_in[1] = 1'b0;
    repeat (3) tick;
    signal_in[1] = 1'b1;
    n_fall = 0;
    repeat (10) begin tick; n_fall += fall_pulse[1]; end
    chk("glitch_level", level_out[1], 1'b1);
    chk("glitch_nopulse", n_fall, 0);
    signal_in[1] = 1'b0;
    repeat (4) tick;
    signal_in[1] = 1'b1;
    n_rise = 0; n_fall = 0;
    repeat (12) begin tick; n_rise += rise_pulse[1]; n_fall += fall_pulse[1]; end
    chk("min_fall", n_fall, 1);
    chk("min_rise", n_rise, 1);

    // ch2 mode 11: clear coincident with the event loses to it.
    edge_mode = 8'b00_11_00_00;
    event_clear = '1; tick; event_clear = '0; tick;
    signal_in[2] = 1'b0;
    repeat (6) tick;
    chk("fall2_pulse", fall_pulse[2], 1'b1);
    event_clear[2] = 1'b1;
    tick;
    event_clear = '0;
    chk("set_wins", event_pending[2], 1'b1);
    event_clear[2] = 1'b1;
    tick;
    event_clear = '0;
    chk("clear2", event_pending[2], 1'b0);
    chk("irq_hold", irq, 1'b1);
    tick;
    chk("irq_drop", irq, 1'b0);

    // ch3 mode 00: pulses still toggle, no pending.
    edge_mode = 8'b00_00_00_00;
    n_rise = 0; n_fall = 0;
    signal_in[3] = 1'b0;
    repeat (8) begin tick; n_fall += fall_pulse[3]; end
    signal_in[3] = 1'b1;
    repeat (8) begin tick; n_rise += rise_pulse[3]; end
    chk("mode0_fall", n_fall, 1);
    chk("mode0_rise", n_rise, 1);
    chk("mode0_pend", event_pending[3], 1'b0);

    // Reset while ch3's filter count is at 2.
    signal_in[3] = 1'b0;
    repeat (4) tick;
    #2 reset = 1'b0;
    #1;
    chk("midrst_level", level_out, 4'hF);
    chk("midrst_pulses", rise_pulse | fall_pulse, 4'h0);
    chk("midrst_pend", event_pending, 4'h0);
    chk("midrst_irq", irq, 1'b0);
    signal_in = '1;
    tick;
    reset = 1'b1;
    n_rise = 0; n_fall = 0;
    repeat (10) begin tick; n_rise += $countones(rise_pulse); n_fall += $countones(fall_pulse); end
    chk("post_rst_pulses", n_rise + n_fall, 0);

`ifdef EDGE_DETECT_COUNT_EN
    // Five rises on ch0 saturate a 2-bit counter at 3.
    edge_mode = 8'b00_00_00_01;
    event_clear = '1; tick; event_clear = '0;
    repeat (5) begin
      signal_in[0] = 1'b0; repeat (8) tick;
      signal_in[0] = 1'b1; repeat (8) tick;
    end
    chk("count_sat", event_count[CW-1:0], 3);
    event_clear[0] = 1'b1; tick; event_clear = '0;
    chk("count_clear", event_count[CW-1:0], 0);
`endif

    // Randomized traffic with random modes, clears and one mid-run reset.
    for (int c = 0; c < CH; c++) hold[c] = 1;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] == 0) begin
          signal_in[c] = ~signal_in[c];
          hold[c] = $urandom_range(1, 9);
        end
      end
      if ($urandom_range(0, 39) == 0) edge_mode = 8'($urandom);
      event_clear = 4'($urandom) & 4'($urandom) & 4'($urandom);
      if (i == 400) begin
        #2 reset = 1'b0;
        tick;
        reset = 1'b1;
      end else begin
        tick;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
